// File: rtl/gamepad_input_ctrl.sv
// SNES-style pad reader: once per frame latches the pad, shifts in 16 bits,
// then publishes the debounced/cancelled/auto-repeated button word with a strobe.
module gamepad_input_ctrl #(
  parameter int PAD_DIV     = 150,
  parameter int MOVE_REPEAT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [9:0] input_data,
  output logic       trigger,
  output logic       pad_present
);

  localparam int DW = $clog2(PAD_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(2*PAD_DIV - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(PAD_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT, UPDATE, EMIT} state_t;

  state_t      r_state, w_next;
  logic [DW-1:0] r_div;
  logic [3:0]  r_bit;
  logic [15:0] r_raw;
  logic        r_b_prev;
  logic [3:0]  r_dir_prev;
  logic [5:0]  r_rpt;

  logic        w_div_end;
  logic        w_present;
  logic [15:0] w_pressed;
  logic        w_ud_x, w_lr_x;
  logic [3:0]  w_dirs, w_report;
  logic [5:0]  w_rpt_inc, w_rpt_nxt;
  logic [9:0]  w_data;

  assign w_div_end = (r_div == DIV_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_start) w_next = LATCH;
      LATCH:   if (w_div_end) w_next = SHIFT;
      SHIFT:   if (w_div_end && r_bit == 4'd15) w_next = UPDATE;
      UPDATE:  w_next = EMIT;
      EMIT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    pad_latch = (r_state == LATCH);
    pad_clk   = !((r_state == SHIFT) && (r_div <= DIV_MID));
    trigger   = (r_state == EMIT);
  end

  // An absent pad reads all-zero pressed bits, which also clears the history.
  assign w_present = &r_raw[15:12];
  assign w_pressed = w_present ? ~r_raw : 16'h0000;
  assign w_ud_x    = w_pressed[4] & w_pressed[5];
  assign w_lr_x    = w_pressed[6] & w_pressed[7];
  assign w_dirs    = {w_pressed[7] & ~w_lr_x, w_pressed[6] & ~w_lr_x,
                      w_pressed[5] & ~w_ud_x, w_pressed[4] & ~w_ud_x};
  assign w_rpt_inc = r_rpt + 6'd1;

  always_comb begin
    w_report  = 4'b0000;
    w_rpt_nxt = 6'd0;
    if ((w_dirs & ~r_dir_prev) != 4'b0000) begin
      w_report = w_dirs;
    end else if (w_dirs != 4'b0000) begin
      if (w_rpt_inc == 6'(MOVE_REPEAT)) w_report  = w_dirs;
      else                              w_rpt_nxt = w_rpt_inc;
    end
  end

  assign w_data = {w_pressed[0] & ~r_b_prev, w_report[3], w_report[2], w_report[1],
                   w_report[0], w_pressed[0], w_pressed[8], w_pressed[3],
                   w_pressed[2], w_pressed[1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div       <= '0;
      r_bit       <= 4'd0;
      r_raw       <= 16'h0000;
      r_b_prev    <= 1'b0;
      r_dir_prev  <= 4'b0000;
      r_rpt       <= 6'd0;
      input_data  <= 10'h000;
      pad_present <= 1'b0;
    end else begin
      if (r_state == LATCH || r_state == SHIFT)
        r_div <= w_div_end ? '0 : r_div + DW'(1);
      else
        r_div <= '0;

      if (r_state == IDLE)
        r_bit <= 4'd0;
      else if (r_state == SHIFT && w_div_end)
        r_bit <= r_bit + 4'd1;

      // sample on the last cycle of each low phase
      if (r_state == SHIFT && r_div == DIV_MID)
        r_raw[r_bit] <= pad_data;

      if (r_state == UPDATE) begin
        input_data  <= w_data;
        pad_present <= w_present;
        r_b_prev    <= w_pressed[0];
        r_dir_prev  <= w_dirs;
        r_rpt       <= w_rpt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_input_ctrl.sv
// Directed bench: pad shift-register model, frame timing checks, and a
// scoreboard of expected button words popped at each trigger.
module tb_gamepad_input_ctrl;
  localparam int PD = 4;
  localparam int MR = 8;
  localparam int TRIG_CYC = 34*PD + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, trigger, pad_present;
  logic [9:0] input_data;

  gamepad_input_ctrl #(.PAD_DIV(PD), .MOVE_REPEAT(MR)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .input_data(input_data),
    .trigger(trigger), .pad_present(pad_present)
  );

  always #5 clk = ~clk;

  // Pad model: latch reloads, each pad_clk rising edge advances one bit.
  logic [15:0] btn = 16'hFFFF;
  logic        tie0 = 1'b0;
  int          bidx = 0;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) bidx = 0;
    else if (bidx < 16) bidx = bidx + 1;
  end
  always_comb pad_data = tie0 ? 1'b0 : ((bidx < 16) ? btn[bidx] : 1'b1);

  typedef struct packed { logic [9:0] data; logic present; } exp_t;
  exp_t q[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] b, input logic t0,
                           input logic [9:0] ed, input logic ep,
                           input int fs2, input int abort_at);
    exp_t got;
    int ntrig = 0, tcyc = -1, lat_err = 0, clk_err = 0;
    logic exp_latch, exp_clk;
    btn  = b;
    tie0 = t0;
    @(negedge clk);
    frame_start = 1'b1;
    if (abort_at < 0) q.push_back('{ed, ep});
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      frame_start = (n == fs2);
      if (n == abort_at) reset = 1'b0;
      if (abort_at > 0 && n == abort_at + 1) begin
        chk({tag, "_rst_clk"},   pad_clk,    1);
        chk({tag, "_rst_latch"}, pad_latch,  0);
        chk({tag, "_rst_data"},  input_data, 0);
        chk({tag, "_rst_trig"},  trigger,    0);
        reset = 1'b1;
        break;
      end
      if (abort_at < 0) begin
        exp_latch = (n >= 1 && n <= 2*PD);
        exp_clk   = !(n >= 2*PD+1 && n <= 34*PD && ((n - 2*PD - 1) % (2*PD)) < PD);
        if (pad_latch !== exp_latch) lat_err++;
        if (pad_clk !== exp_clk) clk_err++;
        if (trigger === 1'b1) begin
          ntrig++;
          tcyc = n;
          chk({tag, "_qsize"}, q.size(), 1);
          if (q.size() > 0) begin
            got = q.pop_front();
            chk({tag, "_data"},    input_data,  got.data);
            chk({tag, "_present"}, pad_present, got.present);
          end
        end
      end
    end
    if (abort_at < 0) begin
      chk({tag, "_ntrig"},   ntrig,   1);
      chk({tag, "_trigcyc"}, tcyc,    TRIG_CYC);
      chk({tag, "_latch"},   lat_err, 0);
      chk({tag, "_padclk"},  clk_err, 0);
    end else begin
      // aborted read must never produce a trigger
      for (int n = 0; n < 150; n++) begin
        @(negedge clk);
        if (trigger === 1'b1) ntrig++;
      end
      chk({tag, "_notrig"}, ntrig, 0);
      chk({tag, "_data0"},  input_data, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_latch",   pad_latch,   0);
    chk("reset_padclk",  pad_clk,     1);
    chk("reset_data",    input_data,  0);
    chk("reset_trig",    trigger,     0);
    chk("reset_present", pad_present, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Up+B: new press edge, then held, then auto-repeat on the 8th held frame
    run_frame("f1_upb",  16'hFFEE, 1'b0, 10'h230, 1'b1, -1, -1);
    run_frame("f2_held", 16'hFFEE, 1'b0, 10'h010, 1'b1, -1, -1);
    for (int f = 3; f <= 8; f++)
      run_frame($sformatf("f%0d_held", f), 16'hFFEE, 1'b0, 10'h010, 1'b1, -1, -1);
    run_frame("f9_rpt",  16'hFFEE, 1'b0, 10'h030, 1'b1, -1, -1);
    run_frame("release", 16'hFFFF, 1'b0, 10'h000, 1'b1, -1, -1);
    // L+R cancel, Up still reported; then Up released with L+R held
    run_frame("lru",     16'hFF2F, 1'b0, 10'h020, 1'b1, -1, -1);
    run_frame("lr_only", 16'hFF3F, 1'b0, 10'h000, 1'b1, -1, -1);
    // A/Start/Select/Y plus unused X/L/R
    run_frame("misc",    16'hF0F1, 1'b0, 10'h00F, 1'b1, -1, -1);
    run_frame("absent",  16'hFFFF, 1'b1, 10'h000, 1'b0, -1, -1);
    // B edge again after absence; second frame_start at cycle 50 ignored
    run_frame("dupfs",   16'hFFFE, 1'b0, 10'h210, 1'b1, 50, -1);
    run_frame("abort",   16'hFFEE, 1'b0, 10'h000, 1'b0, -1, 60);
    run_frame("post_rst",16'hFF5E, 1'b0, 10'h350, 1'b1, -1, -1);
    // Up+Down cancel with new Left
    run_frame("udl",     16'hFF8F, 1'b0, 10'h080, 1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
